// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back arbiter slice.
package wb_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned XZR_IDX = 31;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_ALU  = 2'd2
  } sel_t;

endpackage

// File: rtl/wb_fifo.sv
// ALU result FIFO with per-entry valid bits, in-place squash by destination
// register, and a per-entry match vector for hazard lookups.
module wb_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [REG_AW-1:0] i_push_rd,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_squash,
  input  logic [REG_AW-1:0] i_squash_rd,
  input  logic [REG_AW-1:0] i_chk_rd,
  output logic              o_head_vld,
  output logic [REG_AW-1:0] o_head_rd,
  output logic [DATA_W-1:0] o_head_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [QDEPTH-1:0] o_match
);

  localparam int unsigned PW = $clog2(QDEPTH);

  logic [PW:0]       r_wptr;
  logic [PW:0]       r_rptr;
  logic [QDEPTH-1:0] r_vld;
  logic [DATA_W-1:0] r_data [QDEPTH];
  logic [REG_AW-1:0] r_rd   [QDEPTH];

  logic [PW-1:0] w_widx;
  logic [PW-1:0] w_ridx;

  assign w_widx = r_wptr[PW-1:0];
  assign w_ridx = r_rptr[PW-1:0];

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (w_widx == w_ridx);

  assign o_head_vld  = r_vld[w_ridx];
  assign o_head_rd   = r_rd[w_ridx];
  assign o_head_data = r_data[w_ridx];

  // Payload needs no reset: valid bits alone decide whether an entry counts.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_data[w_widx] <= i_push_data;
      r_rd[w_widx]   <= i_push_rd;
    end
  end

  // Squash is applied first so a same-cycle push into the free slot survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_vld  <= '0;
    end else begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (i_squash && r_vld[i] && (r_rd[i] == i_squash_rd)) begin
          r_vld[i] <= 1'b0;
        end
      end
      if (i_pop) begin
        r_vld[w_ridx] <= 1'b0;
        r_rptr        <= r_rptr + (PW+1)'(1);
      end
      if (i_push) begin
        r_vld[w_widx] <= 1'b1;
        r_wptr        <= r_wptr + (PW+1)'(1);
      end
    end
  end

  always_comb begin
    o_match = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      o_match[i] = r_vld[i] && (r_rd[i] == i_chk_rd);
    end
  end

  // Unoccupied slots always hold vld=0, so the match vector needs no range test.
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst) i_pop |-> !o_empty);
  a_no_push_full : assert property (@(posedge clk) disable iff (rst) i_push |-> !o_full);

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: load returns always win, ALU results are
// queued and drained on idle cycles; also answers pending-write queries.
module wb_arbiter #(
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned REG_AW = wb_pkg::REG_AW,
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] chk_rd,
  output logic              chk_hit,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic [REG_AW-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic [CNT_W-1:0]  stall_cnt
);

  import wb_pkg::*;

  localparam logic [REG_AW-1:0] XZR = REG_AW'(XZR_IDX);

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_head_vld;
  logic [REG_AW-1:0] w_head_rd;
  logic [DATA_W-1:0] w_head_data;
  logic [QDEPTH-1:0] w_match;
  sel_t              w_sel;

  logic              r_memtoreg;
  logic              r_regwrite;
  logic [REG_AW-1:0] r_writereg;
  logic [DATA_W-1:0] r_writedata;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign alu_ready = !w_full;
  // Writes to the zero register are dropped before they take a FIFO slot.
  assign w_push    = alu_valid && !w_full && (alu_rd != XZR);
  assign w_pop     = (w_sel == SEL_ALU);

  always_comb begin
    w_sel = SEL_NONE;
    if (mem_valid) begin
      w_sel = SEL_MEM;
    end else if (!w_empty) begin
      w_sel = SEL_ALU;
    end
  end

  wb_fifo #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW),
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .i_push     (w_push),
    .i_push_rd  (alu_rd),
    .i_push_data(alu_result),
    .i_pop      (w_pop),
    .i_squash   (mem_valid),
    .i_squash_rd(mem_rd),
    .i_chk_rd   (chk_rd),
    .o_head_vld (w_head_vld),
    .o_head_rd  (w_head_rd),
    .o_head_data(w_head_data),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_match    (w_match)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_memtoreg  <= 1'b0;
      r_regwrite  <= 1'b0;
      r_writereg  <= '0;
      r_writedata <= '0;
    end else begin
      unique case (w_sel)
        SEL_MEM: begin
          r_memtoreg  <= 1'b1;
          r_regwrite  <= (mem_rd != XZR);
          r_writereg  <= mem_rd;
          r_writedata <= mem_data;
        end
        SEL_ALU: begin
          // A squashed head is consumed here but never reaches the register file.
          r_memtoreg  <= 1'b0;
          r_regwrite  <= w_head_vld && (w_head_rd != XZR);
          r_writereg  <= w_head_rd;
          r_writedata <= w_head_data;
        end
        default: begin
          r_regwrite  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (alu_valid && w_full && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign chk_hit = (chk_rd != XZR) &&
                   ((|w_match) ||
                    (r_regwrite && (r_writereg == chk_rd)) ||
                    (mem_valid && (mem_rd == chk_rd)));

  assign MemtoReg  = r_memtoreg;
  assign RegWrite  = r_regwrite;
  assign WriteReg  = r_writereg;
  assign WriteData = r_writedata;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-cycle stimulus table with hand-derived ready/hit
// expectations, and a queue-based model predicting every register-file write.
module tb_wb_arbiter;

  localparam int unsigned QD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [63:0] alu_result;
  logic [4:0]  alu_rd;
  logic        mem_valid;
  logic [63:0] mem_data;
  logic [4:0]  mem_rd;
  logic [4:0]  chk_rd;
  logic        chk_hit;
  logic        MemtoReg;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
  logic [15:0] stall_cnt;

  wb_arbiter #(
    .DATA_W(64),
    .REG_AW(5),
    .QDEPTH(QD),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_result(alu_result),
    .alu_rd    (alu_rd),
    .mem_valid (mem_valid),
    .mem_data  (mem_data),
    .mem_rd    (mem_rd),
    .chk_rd    (chk_rd),
    .chk_hit   (chk_hit),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [63:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [63:0] md;
    logic [4:0]  chk;
    logic        e_rdy;
    logic        e_hit;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
    logic        v;
  } ent_t;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [63:0] d;
    logic        m;
  } wr_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic [15:0] m_stall = '0;
  ent_t mq[$];
  wr_t  sb[$];
  vec_t tbl[19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                              input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                              input logic [4:0] c, input logic er, input logic eh);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.chk = c; v.e_rdy = er; v.e_hit = eh;
    return v;
  endfunction

  task automatic step(input vec_t v);
    logic rdy;
    ent_t e;
    wr_t  w;
    alu_valid  = v.av;
    alu_rd     = v.ard;
    alu_result = v.ad;
    mem_valid  = v.mv;
    mem_rd     = v.mrd;
    mem_data   = v.md;
    chk_rd     = v.chk;
    #1;
    chk("alu_ready", {63'd0, alu_ready}, {63'd0, v.e_rdy});
    chk("chk_hit", {63'd0, chk_hit}, {63'd0, v.e_hit});
    rdy = (mq.size() < QD);
    if (v.mv) begin
      if (v.mrd != 5'd31) sb.push_back(wr_t'{cyc, v.mrd, v.md, 1'b1});
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].rd == v.mrd) mq[i].v = 1'b0;
      end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.v) sb.push_back(wr_t'{cyc, e.rd, e.d, 1'b0});
    end
    if (v.av && rdy && (v.ard != 5'd31)) mq.push_back(ent_t'{v.ard, v.ad, 1'b1});
    if (v.av && !rdy && (m_stall != 16'hFFFF)) m_stall++;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      w = sb.pop_front();
      chk("RegWrite", {63'd0, RegWrite}, 64'd1);
      chk("WriteReg", {59'd0, WriteReg}, {59'd0, w.rd});
      chk("WriteData", WriteData, w.d);
      chk("MemtoReg", {63'd0, MemtoReg}, {63'd0, w.m});
    end else begin
      chk("RegWrite_idle", {63'd0, RegWrite}, 64'd0);
    end
    cyc++;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_RegWrite"}, {63'd0, RegWrite}, 64'd0);
    chk({tag, "_MemtoReg"}, {63'd0, MemtoReg}, 64'd0);
    chk({tag, "_WriteReg"}, {59'd0, WriteReg}, 64'd0);
    chk({tag, "_WriteData"}, WriteData, 64'd0);
    chk({tag, "_stall_cnt"}, {48'd0, stall_cnt}, 64'd0);
    chk({tag, "_alu_ready"}, {63'd0, alu_ready}, 64'd1);
    chk({tag, "_chk_hit"}, {63'd0, chk_hit}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    chk_rd = 5'd1;
    repeat (2) @(negedge clk);
    chk_reset_state("rst0");
    reset = 1'b0;

    //          av ard   ad        mv mrd   md         chk   rdy hit
    tbl[0]  = mk(1, 5'd5,  64'h1234, 0, 5'd0,  64'h0,    5'd5,  1, 0);
    tbl[1]  = mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    5'd5,  1, 1);
    tbl[2]  = mk(1, 5'd3,  64'h33,   1, 5'd7,  64'hDEAD, 5'd7,  1, 1);
    tbl[3]  = mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    5'd3,  1, 1);
    tbl[4]  = mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    5'd3,  1, 1);
    tbl[5]  = mk(1, 5'd9,  64'h1,    0, 5'd0,  64'h0,    5'd9,  1, 0);
    tbl[6]  = mk(0, 5'd0,  64'h0,    1, 5'd9,  64'h2,    5'd9,  1, 1);
    tbl[7]  = mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    5'd9,  1, 1);
    tbl[8]  = mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    5'd9,  1, 0);
    tbl[9]  = mk(1, 5'd31, 64'hFF,   1, 5'd31, 64'hEE,   5'd31, 1, 0);
    tbl[10] = mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    5'd31, 1, 0);
    tbl[11] = mk(1, 5'd1,  64'h11,   1, 5'd10, 64'hA0,   5'd1,  1, 0);
    tbl[12] = mk(1, 5'd2,  64'h22,   1, 5'd11, 64'hB0,   5'd1,  1, 1);
    tbl[13] = mk(1, 5'd3,  64'h33,   1, 5'd12, 64'hC0,   5'd2,  0, 1);
    tbl[14] = mk(1, 5'd3,  64'h33,   1, 5'd13, 64'hD0,   5'd3,  0, 0);
    tbl[15] = mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    5'd1,  0, 1);
    tbl[16] = mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    5'd2,  1, 1);
    tbl[17] = mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    5'd2,  1, 1);
    tbl[18] = mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    5'd4,  1, 0);

    for (int i = 0; i < 19; i++) step(tbl[i]);

    chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, m_stall});
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Fill the FIFO with two entries while a load is being written, then reset mid-cycle.
    step(mk(1, 5'd1, 64'h111, 1, 5'd20, 64'h200, 5'd0, 1, 0));
    step(mk(1, 5'd2, 64'h222, 1, 5'd21, 64'h210, 5'd1, 1, 1));
    chk("pre_rst_RegWrite", {63'd0, RegWrite}, 64'd1);
    chk("pre_rst_full", {63'd0, alu_ready}, 64'd0);
    #2 reset = 1'b1;
    #1;
    chk_reset_state("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    sb.delete();
    m_stall = '0;
    repeat (3) step(mk(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd1, 1, 0));
    chk("post_rst_stall", {48'd0, stall_cnt}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
